// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and 8N1 frame defaults.
// The CLKS_PER_BIT default is common to uart_tx and uart_rx so both ends agree.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 868;  // 100 MHz / 115200
  localparam int DATA_BITS_DEF    = 8;    // one start bit, LSB first, one stop bit

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input.
// RESET_VAL should match the input's idle level so reset does not fake an edge.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: synchronised line, mid-bit sampling, one-byte holding
// register on a valid/ready handshake, with framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] T_MID    = TW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [TW-1:0] T_END    = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 w_rx_s;
  rx_state_e            r_state, w_state_nxt;
  logic [TW-1:0]        r_timer, w_timer_nxt;
  logic [BW-1:0]        r_bit_idx, w_bit_idx_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_frame_err, r_overrun;
  logic                 w_stop_good, w_stop_bad, w_load;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (rx),
    .o_q     (w_rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer + 1'b1;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_stop_good   = 1'b0;
    w_stop_bad    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_timer_nxt = '0;
        if (!w_rx_s) w_state_nxt = ST_START;
      end
      ST_START: begin
        if (r_timer == T_MID) begin
          w_timer_nxt = '0;
          // A start bit that is high again at its midpoint was a glitch
          if (!w_rx_s) begin
            w_state_nxt   = ST_DATA;
            w_bit_idx_nxt = '0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (r_timer == T_END) begin
          w_timer_nxt = '0;
          w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
          if (r_bit_idx == LAST_BIT) w_state_nxt   = ST_STOP;
          else                       w_bit_idx_nxt = r_bit_idx + 1'b1;
        end
      end
      ST_STOP: begin
        if (r_timer == T_END) begin
          w_timer_nxt = '0;
          w_stop_good = w_rx_s;
          w_stop_bad  = !w_rx_s;
          w_state_nxt = w_rx_s ? ST_IDLE : ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        w_timer_nxt = '0;
        if (w_rx_s) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_timer_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The held byte counts as consumed if it is accepted in the same cycle
  assign w_load = w_stop_good && (!r_valid || rx_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer     <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_timer     <= w_timer_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_frame_err <= w_stop_bad;
      r_overrun   <= w_stop_good && !w_load;
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16: the bench plays the serial
// transmitter and collects delivered bytes and error pulses on the falling edge.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  logic rdy_main = 1'b0;
  logic tog_en   = 1'b0;
  logic tog_val  = 1'b0;

  int n_vec = 0;
  int n_mis = 0;
  int n_fe = 0, n_ov = 0, n_both = 0;
  logic [7:0] got[$];

  assign rx_ready = tog_en ? tog_val : rdy_main;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tog_val <= ~tog_val;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && rx_ready) got.push_back(rx_data);
      if (frame_err) n_fe++;
      if (overrun) n_ov++;
      if (frame_err && overrun) n_both++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopv);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stopv;
    tick(CPB);
    rx = 1'b1;
  endtask

  function automatic logic [31:0] got_at(input int i);
    return (got.size() > i) ? {24'h0, got[i]} : 32'hDEAD;
  endfunction

  int gb, fb, ob;

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    tick(3);
    @(negedge clk);
    chk("rst_data", rx_data, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_ov", overrun, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick(5);

    // Single frame 0xA5, consumer always ready
    rdy_main = 1'b1;
    gb = got.size(); fb = n_fe; ob = n_ov;
    send_frame(8'hA5, 1'b1);
    tick(4);
    chk("a5_count", got.size() - gb, 1);
    chk("a5_data", got_at(gb), 8'hA5);
    chk("a5_fe", n_fe - fb, 0);
    chk("a5_ov", n_ov - ob, 0);
    chk("a5_valid_low", rx_valid, 0);

    // 5-cycle low glitch on an idle line
    gb = got.size(); fb = n_fe;
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    chk("glitch_busy_hi", busy, 1);
    for (int i = 0; i < 12 && busy; i++) tick(1);
    chk("glitch_busy_drop", busy, 0);
    tick(20);
    chk("glitch_nobyte", got.size() - gb, 0);
    chk("glitch_nofe", n_fe - fb, 0);

    // 0x3C with a low stop bit, line held low, then recovery with 0x55
    gb = got.size(); fb = n_fe;
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    tick(40);
    rx = 1'b1;
    tick(5);
    chk("ferr_once", n_fe - fb, 1);
    chk("ferr_nobyte", got.size() - gb, 0);
    chk("ferr_busy_clr", busy, 0);
    send_frame(8'h55, 1'b1);
    tick(4);
    chk("after_ferr_count", got.size() - gb, 1);
    chk("after_ferr_data", got_at(gb), 8'h55);
    chk("after_ferr_fe", n_fe - fb, 1);

    // Overrun: consumer stalled across two back-to-back frames
    rdy_main = 1'b0;
    gb = got.size(); fb = n_fe; ob = n_ov;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(4);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_pulse", n_ov - ob, 1);
    chk("ovr_nofe", n_fe - fb, 0);
    rdy_main = 1'b1;
    tick(1);
    rdy_main = 1'b0;
    @(negedge clk);
    chk("ovr_valid_clr", rx_valid, 0);
    chk("ovr_count", got.size() - gb, 1);
    chk("ovr_got", got_at(gb), 8'h11);
    @(posedge clk); #1;

    // Loopback stream with rx_ready toggling every cycle
    rdy_main = 1'b1;
    gb = got.size(); fb = n_fe; ob = n_ov;
    tog_en = 1'b1;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h80, 1'b1);
    send_frame(8'h01, 1'b1);
    tick(6);
    tog_en = 1'b0;
    chk("lb_count", got.size() - gb, 4);
    chk("lb_b0", got_at(gb), 8'h00);
    chk("lb_b1", got_at(gb + 1), 8'hFF);
    chk("lb_b2", got_at(gb + 2), 8'h80);
    chk("lb_b3", got_at(gb + 3), 8'h01);
    chk("lb_fe", n_fe - fb, 0);
    chk("lb_ov", n_ov - ob, 0);

    // Reset during data bit 4 of 0xF0, then 0x0F
    gb = got.size(); fb = n_fe; ob = n_ov;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0;
      tick(CPB);
    end
    rx = 1'b1;
    tick(CPB / 2);
    chk("abort_busy_pre", busy, 1);
    reset = 1'b1;
    tick(1);
    @(negedge clk);
    chk("abort_rst_busy", busy, 0);
    chk("abort_rst_valid", rx_valid, 0);
    chk("abort_rst_data", rx_data, 0);
    chk("abort_rst_fe", frame_err, 0);
    chk("abort_rst_ov", overrun, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick(20);
    chk("abort_nobyte", got.size() - gb, 0);
    send_frame(8'h0F, 1'b1);
    tick(4);
    chk("abort_count", got.size() - gb, 1);
    chk("abort_data", got_at(gb), 8'h0F);
    chk("abort_fe", n_fe - fb, 0);
    chk("abort_ov", n_ov - ob, 0);

    chk("fe_ov_exclusive", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART 8N1 receiver: the stage downstream of the transmit path, consuming the serial line that the UART transmitter drives.
- Synchronises the asynchronous rx line, detects and validates the start bit, and samples each bit at mid-bit.
- Presents each received byte on a valid/ready handshake, backed by a one-byte holding register.
- Flags framing errors and overruns; used for loopback checks and as the front end of a future RX FIFO/AXI read path.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must match the transmitter setting; minimum 4.
- DATA_BITS, 8, data bits per frame; sent LSB first.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rx  input  1  serial line, asynchronous, idle high
- rx_data  output  DATA_BITS  received byte; stable while rx_valid=1
- rx_valid  output  1  byte available
- rx_ready  input  1  consumer accepts byte when rx_valid && rx_ready
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: byte completed while holding register still full
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high on reset.
- Reset values:
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchroniser flops=1, state=IDLE, counters=0.
- Reset asserted mid-frame aborts the frame immediately; no partial byte is delivered.
- Input synchroniser: rx passes through 2 flops to give rx_s. All decisions use rx_s, which adds 2 cycles of latency.
- Bit timer: counts 0..CLKS_PER_BIT-1. Width is clog2(CLKS_PER_BIT). Bit index width is clog2(DATA_BITS).
- FSM states:
  - IDLE: when rx_s==0, go to START with timer=0.
  - START: at timer==(CLKS_PER_BIT-1)/2 (mid start bit):
    - rx_s==0: go to DATA, timer=0, bit_idx=0.
    - rx_s==1: glitch; return to IDLE with no outputs.
  - DATA: at timer==CLKS_PER_BIT-1:
    - Shift rx_s into the shift register MSB side, so the first received bit ends at bit 0.
    - Reset the timer.
    - If bit_idx==DATA_BITS-1 go to STOP, else increment bit_idx.
  - STOP: at timer==CLKS_PER_BIT-1 (mid stop bit):
    - rx_s==1: byte complete; go to IDLE.
    - rx_s==0: pulse frame_err, drop the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. This covers break conditions and stops a held-low line from re-triggering.
- Delivery (on the cycle the STOP sample is good):
  - If rx_valid==0, or rx_ready==1 in that same cycle: load rx_data and set rx_valid=1 on the next edge. The old byte is consumed in the same cycle.
  - Otherwise: pulse overrun, discard the new byte, keep the old rx_data and rx_valid=1.
- rx_valid clears on the edge after rx_valid && rx_ready, unless a new byte loads in that same cycle.
- Latency: rx_valid rises 1 cycle after the stop-bit mid-sample. From the stop-bit start on the pin this is about CLKS_PER_BIT/2 + 3 cycles.
- Back-to-back frames: a start bit that begins immediately after the stop bit is accepted. IDLE is re-entered at mid stop bit, before the next falling edge.
- frame_err and overrun are never asserted together.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding: IDLE, START, DATA, STOP, WAIT_HIGH (3 bits).
  - Default CLKS_PER_BIT constant, shared with uart_tx.
  - Frame format constants: DATA_BITS=8, one stop bit.
- One sub-module, sync_2ff: a generic 2-flop synchroniser with a reset value parameter. It is reusable for other async inputs.
- FSM, timer, shift register and holding register stay in uart_rx.

Test Plan:
- CLKS_PER_BIT=16, drive frame 0xA5 (start, 1,0,1,0,0,1,0,1 LSB first, stop), rx_ready=1 -> rx_valid pulses once with rx_data=0xA5; frame_err=0, overrun=0.
- Low glitch of 5 cycles on idle rx -> FSM returns to IDLE; no rx_valid, no frame_err; busy deasserts within 8+2 cycles.
- Frame 0x3C with stop bit driven 0, then line held low for 40 cycles, then high -> frame_err pulses exactly once; no rx_valid; next frame 0x55 is received correctly.
- rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_valid=1 with rx_data=0x11 and an overrun pulse at the 0x22 stop. Then rx_ready=1 for one cycle -> rx_valid clears.
- Loopback from uart_tx at the same CLKS_PER_BIT, bytes 0x00, 0xFF, 0x80, 0x01 with rx_ready toggling -> every byte delivered in order; no errors.
- Assert reset for 1 cycle during DATA bit 4 of 0xF0, release, then send 0x0F -> no output for the aborted frame; 0x0F received; all outputs at reset values during reset.
